// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit.
//   - Access width codes carried on req_type / rsp_type.
//   - FSM state encoding.
//   - Alignment helper used when a request is accepted.
package mem_access_unit_pkg;

  // Access width codes
  localparam logic [2:0] WT_WORD  = 3'd0;
  localparam logic [2:0] WT_HALF  = 3'd1;
  localparam logic [2:0] WT_HALFU = 3'd2;
  localparam logic [2:0] WT_BYTE  = 3'd3;
  localparam logic [2:0] WT_BYTEU = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Byte accesses never fault. Half-words need an even address. Everything
  // else, including unknown codes, is checked as a full word.
  function automatic logic is_misaligned(input logic [2:0] wtype,
                                         input logic [1:0] off);
    logic bad;
    case (wtype)
      WT_BYTE, WT_BYTEU: bad = 1'b0;
      WT_HALF, WT_HALFU: bad = off[0];
      default:           bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_store_be_gen.sv
// store_be_gen: combinational byte-enable and write-data lane replication.
// Ports:
//   we        in  1   store=1 / load=0
//   wtype     in  3   access width code
//   off       in  2   byte offset within the word
//   wdata     in  32  right-aligned store data
//   be        out 4   byte enables (all ones for loads)
//   wdata_rep out 32  store data replicated across the addressed lanes
module store_be_gen
  import mem_access_unit_pkg::*;
(
  input  logic        we,
  input  logic [2:0]  wtype,
  input  logic [1:0]  off,
  input  logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep
);

  always_comb begin
    be        = 4'b1111;
    wdata_rep = '0;
    if (we) begin
      // Only HalfWord and Byte have sub-word stores; any other code stores a word.
      case (wtype)
        WT_HALF: begin
          be        = off[1] ? 4'b1100 : 4'b0011;
          wdata_rep = {2{wdata[15:0]}};
        end
        WT_BYTE: begin
          be        = 4'b0001 << off;
          wdata_rep = {4{wdata[7:0]}};
        end
        default: begin
          be        = 4'b1111;
          wdata_rep = wdata;
        end
      endcase
    end
  end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: single-outstanding load/store sequencer between a CPU
// pipeline and a word-wide memory port, with alignment checking and an
// ack timeout.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   req_valid/req_ready              CPU request handshake (ready only when idle)
//   req_we, req_type, req_addr,
//   req_wdata                        request attributes
//   mem_req, mem_we, mem_be,
//   mem_addr, mem_wdata              memory request, held stable while waiting
//   mem_ack, mem_rdata               memory completion pulse and read word
//   rsp_valid                        one-cycle response pulse
//   rsp_rdata, rsp_offset, rsp_type,
//   rsp_err                          response payload for the byte-extract stage
//   stall                            pipeline hold
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic [1:0]  rsp_offset,
  output logic [2:0]  rsp_type,
  output logic        rsp_err,
  output logic        stall
);

  localparam int CNT_W = $clog2(TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state;
  logic [CNT_W-1:0] timeout_cnt;
  logic [3:0]       be_nxt;
  logic [31:0]      wdata_nxt;
  logic             misaligned;

  store_be_gen u_store_be_gen (
    .we        (req_we),
    .wtype     (req_type),
    .off       (req_addr[1:0]),
    .wdata     (req_wdata),
    .be        (be_nxt),
    .wdata_rep (wdata_nxt)
  );

  assign misaligned = is_misaligned(req_type, req_addr[1:0]);
  assign req_ready  = (state == ST_IDLE);
  assign stall      = ((state == ST_IDLE) && req_valid) || (state == ST_ACCESS);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      timeout_cnt <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_be      <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_offset  <= '0;
      rsp_type    <= '0;
      rsp_err     <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        // Accept: misaligned requests skip memory and answer with an error.
        ST_IDLE: begin
          if (req_valid) begin
            rsp_offset  <= req_addr[1:0];
            rsp_type    <= req_type;
            rsp_rdata   <= '0;
            timeout_cnt <= '0;
            if (misaligned) begin
              rsp_err   <= 1'b1;
              rsp_valid <= 1'b1;
              state     <= ST_RESP;
            end else begin
              rsp_err   <= 1'b0;
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_be    <= be_nxt;
              mem_addr  <= {req_addr[31:2], 2'b00};
              mem_wdata <= wdata_nxt;
              state     <= ST_ACCESS;
            end
          end
        end
        // Wait for ack; ack takes priority over a timeout in the same cycle.
        ST_ACCESS: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            rsp_valid <= 1'b1;
            if (!mem_we) rsp_rdata <= mem_rdata;
            state     <= ST_RESP;
          end else if (timeout_cnt == CNT_LAST) begin
            mem_req   <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= ST_RESP;
          end else begin
            timeout_cnt <= timeout_cnt + 1'b1;
          end
        end
        // Response cycle: rsp_valid is high here only.
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_type;
  logic [31:0] req_addr, req_wdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic [1:0]  rsp_offset;
  logic [2:0]  rsp_type;
  logic        rsp_err, stall;

  int n_chk  = 0;
  int n_pass = 0;

  mem_access_unit #(.TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_offset(rsp_offset),
    .rsp_type(rsp_type), .rsp_err(rsp_err), .stall(stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic we, input logic [2:0] t, input logic [31:0] a,
                       input logic [31:0] d);
    req_valid = 1'b1; req_we = we; req_type = t; req_addr = a; req_wdata = d;
  endtask

  int hi_cnt;
  bit seen;

  initial begin
    rst_n = 1'b0; req_valid = 0; req_we = 0; req_type = 0; req_addr = 0;
    req_wdata = 0; mem_ack = 0; mem_rdata = 0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be}, 32'd0);

    // Stray ack while idle must be ignored
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    tick();
    mem_ack = 1'b0;
    chk("idle_ack_ignored", {31'd0, rsp_valid}, 32'd0);

    // Load word 0x100, ack in first ACCESS cycle
    issue(1'b0, 3'd0, 32'h100, 32'h0);
    #1 chk("ld_stall_idle", {31'd0, stall}, 32'd1);
    tick();
    req_valid = 1'b0;
    chk("ld_mem_req", {31'd0, mem_req}, 32'd1);
    chk("ld_mem_be", {28'd0, mem_be}, 32'hF);
    chk("ld_mem_addr", mem_addr, 32'h100);
    chk("ld_mem_we", {31'd0, mem_we}, 32'd0);
    chk("ld_ready_busy", {31'd0, req_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    tick();
    mem_ack = 1'b0;
    chk("ld_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("ld_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
    chk("ld_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("ld_mem_req_drop", {31'd0, mem_req}, 32'd0);
    chk("ld_resp_stall", {31'd0, stall}, 32'd0);
    tick();
    chk("ld_rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    chk("ld_back_idle", {31'd0, req_ready}, 32'd1);

    // Store byte 0x203
    issue(1'b1, 3'd3, 32'h203, 32'h0000_00A5);
    tick();
    req_valid = 1'b0;
    chk("sb_mem_addr", mem_addr, 32'h200);
    chk("sb_mem_be", {28'd0, mem_be}, 32'h8);
    chk("sb_mem_wdata", mem_wdata, 32'hA5A5_A5A5);
    chk("sb_mem_we", {31'd0, mem_we}, 32'd1);
    tick();
    chk("sb_held_be", {28'd0, mem_be}, 32'h8);
    chk("sb_held_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    mem_ack = 1'b0;
    chk("sb_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("sb_rsp_rdata", rsp_rdata, 32'h0);
    chk("sb_rsp_offset", {30'd0, rsp_offset}, 32'd3);
    tick();

    // Store with HalfWordU code behaves as a word store
    issue(1'b1, 3'd2, 32'h300, 32'h1122_3344);
    tick();
    req_valid = 1'b0;
    chk("sw_alias_be", {28'd0, mem_be}, 32'hF);
    chk("sw_alias_wdata", mem_wdata, 32'h1122_3344);
    mem_ack = 1'b1;
    tick(); mem_ack = 1'b0;
    tick();

    // Misaligned HalfWord load 0x101
    issue(1'b0, 3'd1, 32'h101, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("mis_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("mis_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("mis_mem_req", {31'd0, mem_req}, 32'd0);
    chk("mis_rsp_type", {29'd0, rsp_type}, 32'd1);
    chk("mis_rsp_offset", {30'd0, rsp_offset}, 32'd1);
    tick();
    chk("mis_idle", {31'd0, req_ready}, 32'd1);

    // Timeout: no ack ever
    issue(1'b0, 3'd0, 32'h10, 32'h0);
    tick();
    req_valid = 1'b0;
    hi_cnt = 0; seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid) begin seen = 1; break; end
      if (mem_req) hi_cnt++;
      tick();
    end
    chk("to_seen", {31'd0, seen}, 32'd1);
    chk("to_req_cycles", hi_cnt, 32'd16);
    chk("to_rsp_err", {31'd0, rsp_err}, 32'd1);
    chk("to_rsp_rdata", rsp_rdata, 32'h0);
    tick();

    // Ack on the final ACCESS cycle wins over the timeout
    issue(1'b0, 3'd0, 32'h20, 32'h0);
    tick();
    req_valid = 1'b0;
    for (int i = 0; i < 15; i++) tick();
    chk("edge_still_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_0001;
    tick();
    mem_ack = 1'b0;
    chk("edge_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("edge_rsp_err", {31'd0, rsp_err}, 32'd0);
    chk("edge_rsp_rdata", rsp_rdata, 32'hCAFE_0001);
    tick();

    // Store halfword, reset while in ACCESS
    issue(1'b1, 3'd1, 32'h302, 32'h0000_1234);
    tick();
    req_valid = 1'b0;
    chk("sh_mem_be", {28'd0, mem_be}, 32'hC);
    chk("sh_mem_wdata", mem_wdata, 32'h1234_1234);
    chk("sh_mem_addr", mem_addr, 32'h300);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_req", {31'd0, mem_req}, 32'd0);
    chk("rst_async_be", {28'd0, mem_be}, 32'h0);
    chk("rst_async_addr", mem_addr, 32'h0);
    chk("rst_async_wdata", mem_wdata, 32'h0);
    chk("rst_async_we", {31'd0, mem_we}, 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (rsp_valid) seen = 1;
      tick();
    end
    chk("rst_no_rsp", {31'd0, seen}, 32'd0);
    issue(1'b0, 3'd0, 32'h40, 32'h0);
    tick();
    req_valid = 1'b0;
    chk("post_rst_req", {31'd0, mem_req}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_55AA;
    tick();
    mem_ack = 1'b0;
    chk("post_rst_valid", {31'd0, rsp_valid}, 32'd1);
    chk("post_rst_rdata", rsp_rdata, 32'h0000_55AA);
    tick();

    // Back-to-back with req_valid held high
    issue(1'b0, 3'd0, 32'h80, 32'h0);
    #1 chk("b2b_stall0", {31'd0, stall}, 32'd1);
    tick();
    chk("b2b_stall_acc1", {31'd0, stall}, 32'd1);
    chk("b2b_ready_acc1", {31'd0, req_ready}, 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0001;
    tick();
    mem_ack = 1'b0;
    chk("b2b_resp1_stall", {31'd0, stall}, 32'd0);
    chk("b2b_resp1_valid", {31'd0, rsp_valid}, 32'd1);
    chk("b2b_resp1_ready", {31'd0, req_ready}, 32'd0);
    chk("b2b_resp1_req", {31'd0, mem_req}, 32'd0);
    tick();
    chk("b2b_idle_ready", {31'd0, req_ready}, 32'd1);
    chk("b2b_idle_stall", {31'd0, stall}, 32'd1);
    chk("b2b_idle_req", {31'd0, mem_req}, 32'd0);
    tick();
    req_valid = 1'b0;
    chk("b2b_acc2_req", {31'd0, mem_req}, 32'd1);
    chk("b2b_acc2_stall", {31'd0, stall}, 32'd1);
    mem_ack = 1'b1; mem_rdata = 32'h0000_0002;
    tick();
    mem_ack = 1'b0;
    chk("b2b_resp2_rdata", rsp_rdata, 32'h0000_0002);
    chk("b2b_resp2_stall", {31'd0, stall}, 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
